// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store ports
//
// Shares one synchronous single-port block RAM (1-cycle read latency) between
// the CPU fetch port and its data port. Accesses are serialised, the data port
// has priority, and a streak counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants taken while a fetch was waiting.
//
// Ports:
//   clk_in, reset_in          clock (rising edge), synchronous active-high reset
//   if_req/if_addr            fetch request (held until if_ack) and word address
//   if_ack/if_rdata           fetch ack pulse and fetched word (held until next fetch ack)
//   d_req/d_we/d_addr         data request (held until d_ack), write flag, word address
//   d_wdata/d_be              write data and byte enables
//   d_ack/d_rdata             data ack pulse and read word (held until next read ack)
//   mem_en/mem_we             registered RAM enable and byte write enables
//   mem_addr/mem_wdata        registered RAM address and write data
//   mem_rdata                 RAM read data, valid the cycle after an enabled edge
//   owner                     port holding the current/last grant (0=fetch, 1=data)
//   busy                      high while an access is in flight
module mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                owner,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] streak;
    logic          wr_op;

    // A port whose ack is high this cycle is masked so that a requester
    // dropping req on the ack-sampling edge is not granted a second time.
    logic if_elig;
    logic d_elig;
    logic grant_fetch;
    logic grant_data;

    always_comb begin
        if_elig     = if_req & ~if_ack;
        d_elig      = d_req & ~d_ack;
        grant_fetch = if_elig & (~d_elig | (streak == LIMIT));
        grant_data  = d_elig & ~grant_fetch;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= S_IDLE;
            streak    <= '0;
            wr_op     <= 1'b0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Acks are single-cycle pulses.
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_fetch || grant_data) begin
                        mem_en <= 1'b1;
                        owner  <= grant_data;
                        busy   <= 1'b1;
                        state  <= S_ACCESS;
                        if (grant_data) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_we ? d_be : {BE_W{1'b0}};
                            wr_op     <= d_we;
                            // Count data grants that overtook a waiting fetch.
                            if (!if_elig) begin
                                streak <= '0;
                            end else if (streak != LIMIT) begin
                                streak <= streak + CW'(1);
                            end
                        end else begin
                            mem_addr <= if_addr;
                            mem_we   <= '0;
                            wr_op    <= 1'b0;
                            streak   <= '0;
                        end
                    end
                end

                S_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= '0;
                    if (wr_op) begin
                        // Writes complete as soon as the RAM has taken them.
                        d_ack <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (owner) begin
                        d_ack   <= 1'b1;
                        d_rdata <= mem_rdata;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int LIMIT = 4;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner;
    logic          busy;

    mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_be(d_be),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .owner(owner),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;
    bit log_q[$];

    function automatic logic [DW-1:0] init_val(input int i);
        case (i)
            'h010:   return 32'hDEADBEEF;
            'h020:   return 32'hFFFFFFFF;
            'h030:   return 32'hA5A5A5A5;
            default: return 32'hC0DE0000 | i;
        endcase
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Synchronous single-port RAM seen by the DUT.
    logic [DW-1:0] ram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
        mem_rdata <= '0;
        forever begin
            @(posedge clk_in);
            if (mem_en) begin
                mem_rdata <= ram[mem_addr];
                for (int b = 0; b < BW; b++)
                    if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: one transaction at a time, with a latency countdown
    // (1 edge to ack for writes, 2 for reads) and a reference memory updated
    // at grant time.
    logic [DW-1:0] ref_mem [0:4095];
    logic          e_if_ack, e_d_ack, e_mem_en, e_owner, e_busy;
    logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_wdata;
    logic [BW-1:0] e_mem_we;
    logic [AW-1:0] e_mem_addr;

    initial begin : model
        int   m_left;
        int   m_streak;
        bit   m_owner, m_write, ie, de, take_fetch;
        logic [DW-1:0] m_data;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        m_left = 0; m_streak = 0; m_owner = 0; m_write = 0; m_data = '0;
        forever begin
            @(posedge clk_in);
            if (reset_in) begin
                e_if_ack = 0; e_d_ack = 0; e_mem_en = 0; e_owner = 0; e_busy = 0;
                e_if_rdata = '0; e_d_rdata = '0; e_mem_wdata = '0; e_mem_we = '0; e_mem_addr = '0;
                m_left = 0; m_streak = 0;
                started = 1'b1;
            end else begin
                ie = if_req && !e_if_ack;
                de = d_req && !e_d_ack;
                e_if_ack = 0; e_d_ack = 0; e_mem_en = 0; e_mem_we = '0;
                if (m_left == 0) begin
                    if (ie || de) begin
                        take_fetch = ie && (!de || m_streak == LIMIT);
                        e_mem_en = 1; e_busy = 1;
                        if (take_fetch) begin
                            m_streak = 0; m_owner = 0; m_write = 0; m_left = 2;
                            e_mem_addr = if_addr;
                            m_data = ref_mem[if_addr];
                        end else begin
                            m_streak = ie ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                            m_owner = 1; m_write = d_we;
                            e_mem_addr = d_addr;
                            e_mem_wdata = d_wdata;
                            if (d_we) begin
                                e_mem_we = d_be;
                                for (int b = 0; b < BW; b++)
                                    if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
                                m_left = 1;
                            end else begin
                                m_data = ref_mem[d_addr];
                                m_left = 2;
                            end
                        end
                        e_owner = m_owner;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        e_busy = 0;
                        if (m_owner) begin
                            e_d_ack = 1;
                            if (!m_write) e_d_rdata = m_data;
                        end else begin
                            e_if_ack = 1;
                            e_if_rdata = m_data;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (started) begin
            chk("if_ack", {31'b0, if_ack}, {31'b0, e_if_ack});
            chk("d_ack", {31'b0, d_ack}, {31'b0, e_d_ack});
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("mem_en", {31'b0, mem_en}, {31'b0, e_mem_en});
            chk("mem_we", {28'b0, mem_we}, {28'b0, e_mem_we});
            if (e_mem_en) chk("mem_addr", {20'b0, mem_addr}, {20'b0, e_mem_addr});
            if (e_mem_we != '0) chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("owner", {31'b0, owner}, {31'b0, e_owner});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("ack_overlap", {31'b0, if_ack & d_ack}, 32'd0);
            if (mem_en) log_q.push_back(owner);
        end
    end

    task automatic fetch(input logic [AW-1:0] a);
        int k;
        @(posedge clk_in); #1;
        if_req = 1'b1; if_addr = a;
        for (k = 0; k < 30; k++) begin
            @(negedge clk_in);
            if (if_ack) break;
        end
        if (k == 30) chk("if_ack_timeout", {31'b0, if_ack}, 32'd1);
        @(posedge clk_in); #1;
        if_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be);
        int k;
        @(posedge clk_in); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        for (k = 0; k < 30; k++) begin
            @(negedge clk_in);
            if (d_ack) break;
        end
        if (k == 30) chk("d_ack_timeout", {31'b0, d_ack}, 32'd1);
        @(posedge clk_in); #1;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_in = 1'b1;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b0;
        @(negedge clk_in);
        chk("rst_owner", {31'b0, owner}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // Fetch only.
        log_q.delete();
        fetch(12'h010);
        repeat (4) @(negedge clk_in);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_grants", 32'(log_q.size()), 32'd1);

        // Partial write then read back.
        data(1'b1, 12'h020, 32'h12345678, 4'b0011);
        data(1'b0, 12'h020, 32'h0, 4'b0000);
        chk("t2_d_rdata", d_rdata, 32'hFFFF5678);

        // Simultaneous requests: data first, fetch right after.
        log_q.delete();
        fork
            fetch(12'h011);
            data(1'b1, 12'h021, 32'h0BADF00D, 4'b1111);
        join
        chk("t3_grants", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("t3_first_owner", {31'b0, log_q[0]}, 32'd1);
            chk("t3_second_owner", {31'b0, log_q[1]}, 32'd0);
        end
        chk("t3_if_rdata", if_rdata, 32'hC0DE0011);

        // Starvation guard: data re-requests continuously; the fetch port
        // withdraws across each data-ack edge so data keeps winning the
        // following arbitration while fetch is eligible.
        log_q.delete();
        fork
            begin : dproc
                int kk;
                @(posedge clk_in); #1;
                d_req = 1'b1; d_we = 1'b1; d_addr = 12'h100; d_wdata = 32'h55000000; d_be = 4'hF;
                for (int n = 0; n < 6; n++) begin
                    for (kk = 0; kk < 40; kk++) begin
                        @(negedge clk_in);
                        if (d_ack) break;
                    end
                    if (kk == 40) chk("t4_d_ack_timeout", {31'b0, d_ack}, 32'd1);
                    @(posedge clk_in); #1;
                    d_addr = 12'h101 + AW'(n); d_wdata = 32'h55000001 + n;
                end
                d_req = 1'b0;
            end
            begin : fproc
                int kf;
                @(posedge clk_in); #1;
                if_req = 1'b1; if_addr = 12'h012;
                for (kf = 0; kf < 60; kf++) begin
                    @(negedge clk_in);
                    if (if_ack) break;
                    if (d_ack) begin
                        if_req = 1'b0;
                        @(posedge clk_in); #1;
                        if_req = 1'b1;
                    end
                end
                if (kf == 60) chk("t4_if_ack_timeout", {31'b0, if_ack}, 32'd1);
                @(posedge clk_in); #1;
                if_req = 1'b0;
            end
        join
        chk("t4_grants", 32'(log_q.size()), 32'd7);
        if (log_q.size() == 7) begin
            for (int i = 0; i < 7; i++)
                chk($sformatf("t4_owner_%0d", i), {31'b0, log_q[i]}, (i == 4) ? 32'd0 : 32'd1);
        end
        chk("t4_if_rdata", if_rdata, 32'hC0DE0012);

        // Reset during the response cycle of a read.
        @(posedge clk_in); #1;
        if_req = 1'b1; if_addr = 12'h040;
        for (k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (mem_en) break;
        end
        if (k == 10) chk("t5_grant_timeout", {31'b0, mem_en}, 32'd1);
        @(posedge clk_in); #1 reset_in = 1'b1;
        @(posedge clk_in); #1 reset_in = 1'b0;
        @(negedge clk_in);
        chk("t5_no_ack", {31'b0, if_ack}, 32'd0);
        chk("t5_mem_en", {31'b0, mem_en}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_if_rdata_cleared", if_rdata, 32'd0);
        for (k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (if_ack) break;
        end
        if (k == 10) chk("t5_ack_timeout", {31'b0, if_ack}, 32'd1);
        @(posedge clk_in); #1 if_req = 1'b0;
        chk("t5_if_rdata", if_rdata, 32'hC0DE0040);

        // Zero byte-enable write leaves memory unchanged.
        data(1'b1, 12'h030, 32'h12345678, 4'b0000);
        data(1'b0, 12'h030, 32'h0, 4'b0000);
        chk("t6_d_rdata", d_rdata, 32'hA5A5A5A5);

        repeat (3) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
